// File: rtl/pa_clic_int_cond.sv
// Per-line interrupt conditioning ahead of the CLIC: sync, debounce,
// edge capture held until the CLIC strobe, sticky overflow flags.
module pa_clic_int_cond #(
  parameter int INT_NUM     = 128,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT_W  = 3
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic [INT_NUM-1:0]    pad_int_raw,
  input  logic [INT_NUM-1:0]    int_edge_mode,
  input  logic [FILT_CNT_W-1:0] filt_thresh,
  input  logic                  clic_clk_en,
  input  logic                  int_cond_ovf_clr,
  input  logic                  pad_yy_scan_mode,
  output logic [INT_NUM-1:0]    pad_clic_int_vld,
  output logic [INT_NUM-1:0]    int_cond_ovf
);

  logic [INT_NUM-1:0]    sync_q [SYNC_STAGES];
  logic [INT_NUM-1:0]    s;
  logic [INT_NUM-1:0]    f_q;
  logic [INT_NUM-1:0]    f_nxt;
  logic [INT_NUM-1:0]    f_dly_q;
  logic [FILT_CNT_W-1:0] cnt_q   [INT_NUM];
  logic [FILT_CNT_W-1:0] cnt_nxt [INT_NUM];
  logic [INT_NUM-1:0]    pend_q;
  logic [INT_NUM-1:0]    pend_nxt;
  logic [INT_NUM-1:0]    ovf_q;
  logic [INT_NUM-1:0]    ovf_nxt;
  logic [INT_NUM-1:0]    rise;
  logic [INT_NUM-1:0]    hold;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_int_raw;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  // >= lets a threshold lowered mid-count take effect at once
  always_comb begin
    f_nxt = f_q;
    for (int i = 0; i < INT_NUM; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (s[i] == f_q[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt_q[i] >= filt_thresh) begin
        f_nxt[i]   = s[i];
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt_q[i] + FILT_CNT_W'(1);
      end
    end
  end

  assign rise = f_q & ~f_dly_q;
  assign hold = pend_q & ~{INT_NUM{clic_clk_en}};

  // a rise coinciding with the strobe re-arms instead of overflowing
  assign pend_nxt = int_edge_mode & (rise | hold);
  assign ovf_nxt  = (int_edge_mode & rise & hold)
                  | (ovf_q & ~{INT_NUM{int_cond_ovf_clr}});

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      f_q     <= '0;
      f_dly_q <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < INT_NUM; i++)
        cnt_q[i] <= '0;
    end else begin
      f_q     <= f_nxt;
      f_dly_q <= f_q;
      pend_q  <= pend_nxt;
      ovf_q   <= ovf_nxt;
      for (int i = 0; i < INT_NUM; i++)
        cnt_q[i] <= cnt_nxt[i];
    end
  end

  assign pad_clic_int_vld = pad_yy_scan_mode ? pad_int_raw
                          : (int_edge_mode & pend_q)
                          | (~int_edge_mode & f_q);
  assign int_cond_ovf = ovf_q;

endmodule

// File: tb/tb_pa_clic_int_cond.sv
// Directed bench for pa_clic_int_cond: vector table plus
// hand sequences for overflow, reset and scan bypass.
module tb_pa_clic_int_cond;

  localparam int N = 128;

  logic         forever_cpuclk = 1'b0;
  logic         cpurst;
  logic [N-1:0] pad_int_raw;
  logic [N-1:0] int_edge_mode;
  logic [2:0]   filt_thresh;
  logic         clic_clk_en;
  logic         int_cond_ovf_clr;
  logic         pad_yy_scan_mode;
  logic [N-1:0] pad_clic_int_vld;
  logic [N-1:0] int_cond_ovf;

  pa_clic_int_cond dut (
    .forever_cpuclk  (forever_cpuclk),
    .cpurst          (cpurst),
    .pad_int_raw     (pad_int_raw),
    .int_edge_mode   (int_edge_mode),
    .filt_thresh     (filt_thresh),
    .clic_clk_en     (clic_clk_en),
    .int_cond_ovf_clr(int_cond_ovf_clr),
    .pad_yy_scan_mode(pad_yy_scan_mode),
    .pad_clic_int_vld(pad_clic_int_vld),
    .int_cond_ovf    (int_cond_ovf)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] mode;
    logic [2:0]   th;
    logic         en;
    logic         clr;
    logic [N-1:0] vld;
    logic [N-1:0] ovf;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [N-1:0] Z   = '0;
  localparam logic [N-1:0] B3  = N'(1) << 3;
  localparam logic [N-1:0] B4  = N'(1) << 4;
  localparam logic [N-1:0] B5  = N'(1) << 5;
  localparam logic [N-1:0] B7  = N'(1) << 7;
  localparam logic [N-1:0] B9  = N'(1) << 9;
  localparam logic [N-1:0] B20 = N'(1) << 20;
  localparam logic [N-1:0] B40 = N'(1) << 40;

  task automatic add(input logic [N-1:0] raw, input logic [N-1:0] mode,
                     input logic [2:0] th, input logic en,
                     input logic clr, input logic [N-1:0] vld,
                     input logic [N-1:0] ovf);
    vec_t v;
    v.raw = raw; v.mode = mode; v.th = th;
    v.en = en; v.clr = clr; v.vld = vld; v.ovf = ovf;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  initial begin
    cpurst = 1'b1;
    pad_int_raw = '0;
    int_edge_mode = '0;
    filt_thresh = '0;
    clic_clk_en = 1'b0;
    int_cond_ovf_clr = 1'b0;
    pad_yy_scan_mode = 1'b0;

    // level mode, T=0, line 20
    add(Z,   Z, 0, 1, 0, Z,   Z);
    add(B20, Z, 0, 1, 0, Z,   Z);
    add(B20, Z, 0, 1, 0, Z,   Z);
    add(B20, Z, 0, 1, 0, B20, Z);
    add(Z,   Z, 0, 1, 0, B20, Z);
    add(Z,   Z, 0, 1, 0, B20, Z);
    add(Z,   Z, 0, 1, 0, Z,   Z);
    // debounce T=3, line 5: two 3-cycle glitches, then a 4-cycle pulse
    add(Z,  Z, 3, 0, 0, Z, Z);
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 3; i++) add(B5, Z, 3, 0, 0, Z, Z);
      for (int i = 0; i < 4; i++) add(Z,  Z, 3, 0, 0, Z, Z);
    end
    for (int i = 0; i < 4; i++) add(B5, Z, 3, 0, 0, Z, Z);
    add(Z, Z, 3, 0, 0, Z, Z);
    for (int i = 0; i < 4; i++) add(Z, Z, 3, 0, 0, B5, Z);
    add(Z, Z, 3, 0, 0, Z, Z);
    add(Z, Z, 3, 0, 0, Z, Z);
    // edge mode line 40, toggling strobe: 1-cycle then 2-cycle hold
    add(B40, B40, 0, 1, 0, Z,   Z);
    add(Z,   B40, 0, 0, 0, Z,   Z);
    add(Z,   B40, 0, 1, 0, Z,   Z);
    add(Z,   B40, 0, 0, 0, B40, Z);
    add(Z,   B40, 0, 1, 0, Z,   Z);
    add(Z,   B40, 0, 0, 0, Z,   Z);
    add(B40, B40, 0, 0, 0, Z,   Z);
    add(Z,   B40, 0, 1, 0, Z,   Z);
    add(Z,   B40, 0, 0, 0, Z,   Z);
    add(Z,   B40, 0, 1, 0, B40, Z);
    add(Z,   B40, 0, 0, 0, B40, Z);
    add(Z,   B40, 0, 1, 0, Z,   Z);
    add(Z,   B40, 0, 0, 0, Z,   Z);
    // strobe held low, two pulses on line 7 -> overflow
    add(B7, B7, 0, 0, 0, Z,  Z);
    add(Z,  B7, 0, 0, 0, Z,  Z);
    add(Z,  B7, 0, 0, 0, Z,  Z);
    add(Z,  B7, 0, 0, 0, B7, Z);
    add(B7, B7, 0, 0, 0, B7, Z);
    add(Z,  B7, 0, 0, 0, B7, Z);
    add(Z,  B7, 0, 0, 0, B7, Z);
    add(Z,  B7, 0, 0, 0, B7, B7);
    add(Z,  B7, 0, 0, 0, B7, B7);
    add(Z,  B7, 0, 1, 0, Z,  B7);
    add(Z,  B7, 0, 0, 1, Z,  Z);
    add(Z,  B7, 0, 0, 0, Z,  Z);
    // line 9: rise during take, then set/clear collision
    add(B9, B9, 0, 0, 0, Z,  Z);
    add(Z,  B9, 0, 0, 0, Z,  Z);
    add(B9, B9, 0, 0, 0, Z,  Z);
    add(Z,  B9, 0, 0, 0, B9, Z);
    add(Z,  B9, 0, 0, 0, B9, Z);
    add(Z,  B9, 0, 1, 0, B9, Z);
    add(B9, B9, 0, 0, 0, B9, Z);
    add(Z,  B9, 0, 0, 0, B9, Z);
    add(Z,  B9, 0, 0, 0, B9, Z);
    add(Z,  B9, 0, 0, 1, B9, B9);
    add(Z,  B9, 0, 1, 0, Z,  B9);
    add(Z,  B9, 0, 0, 1, Z,  Z);

    tick();
    tick();
    cpurst = 1'b0;
    chk("reset_vld", pad_clic_int_vld, Z);
    chk("reset_ovf", int_cond_ovf, Z);

    foreach (vq[i]) begin
      pad_int_raw      = vq[i].raw;
      int_edge_mode    = vq[i].mode;
      filt_thresh      = vq[i].th;
      clic_clk_en      = vq[i].en;
      int_cond_ovf_clr = vq[i].clr;
      tick();
      chk($sformatf("vec%0d_vld", i), pad_clic_int_vld, vq[i].vld);
      chk($sformatf("vec%0d_ovf", i), int_cond_ovf, vq[i].ovf);
    end

    // build pend+ovf on line 3, start a count on line 4, then reset
    int_edge_mode = B3;
    filt_thresh = 3'd0;
    clic_clk_en = 1'b0;
    int_cond_ovf_clr = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pad_int_raw = B3;
      tick();
      pad_int_raw = Z;
      repeat (5) tick();
    end
    chk("pre_rst_vld", pad_clic_int_vld, B3);
    chk("pre_rst_ovf", int_cond_ovf, B3);
    filt_thresh = 3'd3;
    pad_int_raw = B4;
    repeat (3) tick();
    chk("midcount_vld", pad_clic_int_vld, B3);
    cpurst = 1'b1;
    tick();
    chk("rst_vld", pad_clic_int_vld, Z);
    chk("rst_ovf", int_cond_ovf, Z);
    cpurst = 1'b0;
    pad_int_raw = Z;
    repeat (6) tick();
    chk("post_rst_vld", pad_clic_int_vld, Z);
    chk("post_rst_ovf", int_cond_ovf, Z);

    // scan bypass is combinational
    pad_yy_scan_mode = 1'b1;
    pad_int_raw = N'(8'hA5);
    #1;
    chk("scan_a5", pad_clic_int_vld, N'(8'hA5));
    pad_int_raw = N'(8'h5A);
    #1;
    chk("scan_5a", pad_clic_int_vld, N'(8'h5A));
    pad_yy_scan_mode = 1'b0;
    pad_int_raw = Z;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
